// File: rtl/param_address_register_file.sv
// Parametrised address register file: NUM_REGS x WIDTH registers, two combinational read ports,
// sticky wrap flags. Define SP_BOUNDS_EN to guard register SP_INDEX against leaving [SP_MIN, SP_MAX].

module addr_reg_lane #(
    parameter int              WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit              GUARD     = 1'b0,
    parameter logic [WIDTH-1:0] SP_MIN    = '0,
    parameter logic [WIDTH-1:0] SP_MAX    = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       fun,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             blocked
);
    localparam int H = WIDTH / 2;

    logic [WIDTH-1:0] nxt;
    logic             wrap_hit;

    always_comb begin
        nxt      = q;
        wrap_hit = 1'b0;
        case (fun)
            3'b000: begin nxt = q - 1'b1; wrap_hit = (q == '0); end
            3'b001: begin nxt = q + 1'b1; wrap_hit = (q == '1); end
            3'b010: nxt = d;
            3'b011: nxt = '0;
            3'b100: nxt = {{H{1'b0}}, d[H-1:0]};
            3'b101: nxt = {q[WIDTH-1:H], d[H-1:0]};
            3'b110: nxt = {d[H-1:0], q[H-1:0]};
            default: nxt = {{H{d[H-1]}}, d[H-1:0]};
        endcase
    end

    // Only INC/DEC at the stack limits are suppressed; loads are trusted.
    assign blocked = GUARD && en &&
                     (((fun == 3'b001) && (q == SP_MAX)) || ((fun == 3'b000) && (q == SP_MIN)));

    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= RESET_VAL;
            wrap <= 1'b0;
        end else if (en && !blocked) begin
            q <= nxt;
            if (fun == 3'b011)
                wrap <= 1'b0;
            else if (wrap_hit)
                wrap <= 1'b1;
        end
    end
endmodule

module param_address_register_file #(
    parameter int              WIDTH     = 16,
    parameter int              NUM_REGS  = 3,
    parameter int              SEL_W     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int              SP_INDEX  = 2,
    parameter logic [WIDTH-1:0] SP_MIN    = 16'h0100,
    parameter logic [WIDTH-1:0] SP_MAX    = 16'hFFFF
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [WIDTH-1:0]    I,
    input  logic [NUM_REGS-1:0] RegSel,
    input  logic [2:0]          FunSel,
    input  logic [SEL_W-1:0]    OutCSel,
    input  logic [SEL_W-1:0]    OutDSel,
    output logic [WIDTH-1:0]    OutC,
    output logic [WIDTH-1:0]    OutD,
    output logic [NUM_REGS-1:0] WrapFlag,
    output logic                StackFault
);
`ifdef SP_BOUNDS_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif

    logic [NUM_REGS-1:0][WIDTH-1:0] q;
    logic [NUM_REGS-1:0]            blocked;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
        addr_reg_lane #(
            .WIDTH    (WIDTH),
            .RESET_VAL(RESET_VAL),
            .GUARD    (GUARD_EN && (k == SP_INDEX)),
            .SP_MIN   (SP_MIN),
            .SP_MAX   (SP_MAX)
        ) u_lane (
            .clk    (Clock),
            .rst    (Reset),
            .en     (!RegSel[k]),
            .fun    (FunSel),
            .d      (I),
            .q      (q[k]),
            .wrap   (WrapFlag[k]),
            .blocked(blocked[k])
        );
    end

    // With the guard compiled out, blocked is constant zero and this flag never sets.
    always_ff @(posedge Clock) begin
        if (Reset)
            StackFault <= 1'b0;
        else if (|blocked)
            StackFault <= 1'b1;
    end

    always_comb begin
        OutC = '0;
        OutD = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (OutCSel == SEL_W'(k)) OutC = q[k];
            if (OutDSel == SEL_W'(k)) OutD = q[k];
        end
    end
endmodule
